pipeline_pc_gen: RTL and testbench
==================================

# pipeline_pc_gen

Parametrised fetch PC generator for the pipelined core, sitting at the head of the fetch stage. It replaces the single-redirect PC register with several prioritised redirect channels and a pending-redirect latch, so redirects arriving while fetch is stalled are never dropped. It also keeps a configurable-depth PC history and optionally contains a small direct-mapped BTB for next-PC prediction.

## Interface
- XLEN, 32: PC width.
- RESET_PC, 32'h6000_0000: first PC fetched after reset.
- NUM_REDIRECT, 2: redirect channels; index 0 is highest priority (e.g. 0 = trap/flush, 1 = branch mispredict).
- HIST_DEPTH, 2: number of previous PCs retained, ≥1.
- BTB_ENTRIES, 16: BTB entries, power of two ≥2 (used only with PC_BTB_EN).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and history this cycle.
- redirect_valid  in  NUM_REDIRECT  per-channel redirect request.
- redirect_pc  in  NUM_REDIRECT*XLEN  channel i target at bits [i*XLEN +: XLEN].
- btb_upd_valid  in  1  write a BTB entry (taken branch resolved).
- btb_upd_pc  in  XLEN  branch PC to record.
- btb_upd_target  in  XLEN  its target.
- pc  out  XLEN  current fetch PC.
- pc_hist  out  HIST_DEPTH*XLEN  slot k at [k*XLEN +: XLEN]; slot 0 = previous PC.
- pend_valid  out  1  a redirect is latched and not yet applied.
- pred_taken  out  1  BTB hit on current pc (0 when PC_BTB_EN undefined).

## Operation
- Reset: pc = RESET_PC; every pc_hist slot = RESET_PC − 4; pend_valid = 0; pending index cleared; all BTB valid bits = 0; pred_taken = 0 follows.
- Live redirect: lowest active index i among redirect_valid; target = redirect_pc[i].
- Next-PC priority (when not stalled): live redirect > pending redirect > BTB hit target > pc + 4.
- Not stalled: pc ← next-PC; pc_hist[0] ← pc; pc_hist[k] ← pc_hist[k−1]; pending cleared (whether or not it was used).
- Stalled: pc and pc_hist hold. A live redirect is latched into pending if pend_valid = 0, or its index ≤ stored index (equal index: newer overwrites). Otherwise pending unchanged.
- Redirect in same cycle stall deasserts: applied directly; stale pending discarded.
- Arithmetic: pc + 4 wraps modulo 2^XLEN (0xFFFF_FFFC → 0x0000_0000). Redirect and BTB targets used as-is, no alignment masking.
- BTB (PC_BTB_EN): index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[XLEN−1:log2(BTB_ENTRIES)+2]; hit = valid & tag match. Update writes valid, tag, target at index of btb_upd_pc, overwriting any prior entry; updates proceed regardless of stall.

## Timing
- Redirect at cycle N, stall = 0: pc = target at N+1.
- Redirect at N with stall high N..M−1, stall low at M: pc = target at M+1; pend_valid high N+1..M.
- Lookup is combinational on current pc; pred_taken valid in the same cycle as pc.
- Update at N visible to lookups from N+1; lookup hitting same index at N sees old contents.
- rst mid-operation: all state returns to reset values next edge; pending redirect and BTB lost.
- No combinational path from stall or redirect inputs to pc/pc_hist; pred_taken depends only on pc and BTB state.

## Configuration
- PC_BTB_EN defined: BTB storage, lookup and update logic built; BTB hit participates in next-PC priority.
- Undefined: no BTB storage; btb_upd_* ignored; pred_taken tied 0; next-PC is redirect > pending > pc + 4.

## Test plan
- Reset then 3 free-running cycles, no stall -> pc = 0x6000_0000, 0x6000_0004, 0x6000_0008; pc_hist[0] = 0x5FFF_FFFC then 0x6000_0000.
- redirect_valid = 2'b11, targets ch0 = 0x100, ch1 = 0x200, no stall -> pc = 0x100 next cycle.
- Stall high 3 cycles, ch1 redirect 0x200 in cycle 1, ch0 redirect 0x300 in cycle 2, then ch1 redirect 0x400 in cycle 3 -> pend_valid high, pc held; after stall drops pc = 0x300, pend_valid = 0.
- Stall high, ch1 redirect 0x200; on release cycle ch0 redirect 0x500 -> pc = 0x500, pending discarded.
- pc = 0xFFFF_FFFC, no stall -> pc = 0x0000_0000; pc_hist[0] = 0xFFFF_FFFC.
- PC_BTB_EN: update pc 0x6000_0008 → 0x6000_0040; later fetch reaches 0x6000_0008 -> pred_taken = 1, next pc = 0x6000_0040; without macro -> pred_taken = 0, next pc = 0x6000_000C.

Source files
------------

// File: rtl/pipeline_pc_gen_if.sv
// Fetch PC generator port bundle: stall, redirect channels,
// BTB update inputs and PC/history/status outputs.
interface pipeline_pc_gen_if #(
  parameter int XLEN         = 32,
  parameter int NUM_REDIRECT = 2,
  parameter int HIST_DEPTH   = 2
);
  logic                         stall;
  logic [NUM_REDIRECT-1:0]      redirect_valid;
  logic [NUM_REDIRECT*XLEN-1:0] redirect_pc;
  logic                         btb_upd_valid;
  logic [XLEN-1:0]              btb_upd_pc;
  logic [XLEN-1:0]              btb_upd_target;
  logic [XLEN-1:0]              pc;
  logic [HIST_DEPTH*XLEN-1:0]   pc_hist;
  logic                         pend_valid;
  logic                         pred_taken;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output btb_upd_valid, btb_upd_pc, btb_upd_target,
    input  pc, pc_hist, pend_valid, pred_taken
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  btb_upd_valid, btb_upd_pc, btb_upd_target,
    output pc, pc_hist, pend_valid, pred_taken
  );
endinterface

// File: rtl/pipeline_pc_gen.sv
// Fetch PC generator: prioritised redirects, pending latch, PC history.
// Optional direct-mapped BTB built when PC_BTB_EN is defined.
module pipeline_pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = 32'h6000_0000,
  parameter int              NUM_REDIRECT = 2,
  parameter int              HIST_DEPTH   = 2,
  parameter int              BTB_ENTRIES  = 16
) (
  input logic              clk,
  input logic              rst,
  pipeline_pc_gen_if.slave bus
);

  localparam int IW = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hist_q [HIST_DEPTH];
  logic            pend_q, pend_d;
  logic [IW-1:0]   pidx_q, pidx_d;
  logic [XLEN-1:0] ppc_q, ppc_d;

  logic            live;
  logic [IW-1:0]   live_idx;
  logic [XLEN-1:0] live_pc;
  logic            btb_hit;
  logic [XLEN-1:0] btb_tgt;

  // Scan high to low so the lowest active channel wins.
  always_comb begin
    live     = 1'b0;
    live_idx = '0;
    live_pc  = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (bus.redirect_valid[i]) begin
        live     = 1'b1;
        live_idx = IW'(i);
        live_pc  = bus.redirect_pc[i*XLEN +: XLEN];
      end
    end
  end

`ifdef PC_BTB_EN
  localparam int IB = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IB - 2;

  logic            btb_v_q   [BTB_ENTRIES];
  logic [TW-1:0]   btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0] btb_tgt_q [BTB_ENTRIES];
  logic [IB-1:0]   rd_idx;
  logic [IB-1:0]   wr_idx;
  logic            unused_lo;

  assign rd_idx    = pc_q[IB+1:2];
  assign wr_idx    = bus.btb_upd_pc[IB+1:2];
  assign unused_lo = ^bus.btb_upd_pc[1:0];
  assign btb_hit   = btb_v_q[rd_idx] &&
                     (btb_tag_q[rd_idx] == pc_q[XLEN-1:IB+2]);
  assign btb_tgt   = btb_tgt_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < BTB_ENTRIES; e++) begin
        btb_v_q[e] <= 1'b0;
      end
    end else if (bus.btb_upd_valid) begin
      btb_v_q[wr_idx]   <= 1'b1;
      btb_tag_q[wr_idx] <= bus.btb_upd_pc[XLEN-1:IB+2];
      btb_tgt_q[wr_idx] <= bus.btb_upd_target;
    end
  end
`else
  logic unused_btb;

  assign btb_hit    = 1'b0;
  assign btb_tgt    = '0;
  assign unused_btb = ^{bus.btb_upd_valid, bus.btb_upd_pc,
                        bus.btb_upd_target, BTB_ENTRIES[0]};
`endif

  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    pidx_d = pidx_q;
    ppc_d  = ppc_q;
    if (!bus.stall) begin
      pend_d = 1'b0;
      if (live)         pc_d = live_pc;
      else if (pend_q)  pc_d = ppc_q;
      else if (btb_hit) pc_d = btb_tgt;
      else              pc_d = pc_q + XLEN'(4);
    end else if (live && (!pend_q || live_idx <= pidx_q)) begin
      pend_d = 1'b1;
      pidx_d = live_idx;
      ppc_d  = live_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      pend_q <= 1'b0;
      pidx_q <= '0;
      ppc_q  <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_q[k] <= RESET_PC - XLEN'(4);
      end
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      pidx_q <= pidx_d;
      ppc_q  <= ppc_d;
      if (!bus.stall) begin
        hist_q[0] <= pc_q;
        for (int k = 1; k < HIST_DEPTH; k++) begin
          hist_q[k] <= hist_q[k-1];
        end
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pend_valid = pend_q;
  assign bus.pred_taken = btb_hit;

  for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
    assign bus.pc_hist[g*XLEN +: XLEN] = hist_q[g];
  end

endmodule

// File: tb/tb_pipeline_pc_gen.sv
// Directed bench for pipeline_pc_gen with an expected-PC queue.
// Honours PC_BTB_EN for the prediction expectations.
module tb_pipeline_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb [$];

  pipeline_pc_gen_if #(
    .XLEN(32), .NUM_REDIRECT(2), .HIST_DEPTH(2)
  ) bus ();

  pipeline_pc_gen #(
    .XLEN(32), .RESET_PC(32'h6000_0000), .NUM_REDIRECT(2),
    .HIST_DEPTH(2), .BTB_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PC_BTB_EN
  localparam logic [31:0] P_AFTER8 = 32'h6000_0040;
  localparam logic        P_PRED   = 1'b1;
`else
  localparam logic [31:0] P_AFTER8 = 32'h6000_000C;
  localparam logic        P_PRED   = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic [1:0] rv,
                      input logic [31:0] r0, input logic [31:0] r1,
                      input logic [31:0] ep, input logic epd,
                      input string tag);
    exp_t e;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = {r1, r0};
    sb.push_back('{pc: ep, pend: epd});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, bus.pc, e.pc);
    chk({tag, ".pend"}, {31'b0, bus.pend_valid}, {31'b0, e.pend});
    bus.stall          = 1'b0;
    bus.redirect_valid = '0;
    bus.btb_upd_valid  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = '0;
    bus.redirect_pc    = '0;
    bus.btb_upd_valid  = 1'b0;
    bus.btb_upd_pc     = '0;
    bus.btb_upd_target = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.pc", bus.pc, 32'h6000_0000);
    chk("rst.h0", bus.pc_hist[31:0], 32'h5FFF_FFFC);
    chk("rst.h1", bus.pc_hist[63:32], 32'h5FFF_FFFC);
    chk("rst.pend", {31'b0, bus.pend_valid}, 32'd0);
    chk("rst.pred", {31'b0, bus.pred_taken}, 32'd0);
    rst = 1'b0;

    bus.btb_upd_valid  = 1'b1;
    bus.btb_upd_pc     = 32'h6000_0008;
    bus.btb_upd_target = 32'h6000_0040;
    step(0, 2'b00, 0, 0, 32'h6000_0004, 0, "free1");
    chk("free1.h0", bus.pc_hist[31:0], 32'h6000_0000);
    chk("free1.h1", bus.pc_hist[63:32], 32'h5FFF_FFFC);
    step(0, 2'b00, 0, 0, 32'h6000_0008, 0, "free2");
    chk("free2.h0", bus.pc_hist[31:0], 32'h6000_0004);
    chk("free2.h1", bus.pc_hist[63:32], 32'h6000_0000);
    chk("btb.pred", {31'b0, bus.pred_taken}, {31'b0, P_PRED});
    step(0, 2'b00, 0, 0, P_AFTER8, 0, "btb.next");

    step(0, 2'b11, 32'h100, 32'h200, 32'h100, 0, "both");
    chk("both.h0", bus.pc_hist[31:0], P_AFTER8);

    step(1, 2'b10, 0, 32'h200, 32'h100, 1, "stl1");
    step(1, 2'b01, 32'h300, 0, 32'h100, 1, "stl2");
    step(1, 2'b10, 0, 32'h400, 32'h100, 1, "stl3");
    chk("stl3.h0", bus.pc_hist[31:0], P_AFTER8);
    step(0, 2'b00, 0, 0, 32'h300, 0, "rel");
    chk("rel.h0", bus.pc_hist[31:0], 32'h100);

    step(1, 2'b10, 0, 32'h200, 32'h300, 1, "disc.stl");
    step(0, 2'b01, 32'h500, 0, 32'h500, 0, "disc.rel");
    step(0, 2'b00, 0, 0, 32'h504, 0, "disc.after");

    step(0, 2'b10, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, "wrap.set");
    step(0, 2'b00, 0, 0, 32'h0000_0000, 0, "wrap");
    chk("wrap.h0", bus.pc_hist[31:0], 32'hFFFF_FFFC);
    chk("wrap.h1", bus.pc_hist[63:32], 32'h504);

    step(1, 2'b10, 0, 32'h700, 32'h0, 1, "eq1");
    step(1, 2'b10, 0, 32'h800, 32'h0, 1, "eq2");
    step(0, 2'b00, 0, 0, 32'h800, 0, "eq.rel");

    step(1, 2'b01, 32'h900, 0, 32'h800, 1, "mrst.stl");
    rst = 1'b1;
    step(1, 2'b00, 0, 0, 32'h6000_0000, 0, "mrst");
    chk("mrst.h0", bus.pc_hist[31:0], 32'h5FFF_FFFC);
    rst = 1'b0;
    step(0, 2'b00, 0, 0, 32'h6000_0004, 0, "mrst.after");
    chk("mrst.pred", {31'b0, bus.pred_taken}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
